// File: rtl/piso_pkg.sv
// piso_pkg: shared FSM state type and line-level constants for the serial transmitter.
package piso_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/piso_bit_timer.sv
// piso_bit_timer: counts BIT_CYCLES clocks per serial bit, ticks on the last cycle of each bit.
module piso_bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  logic [TW-1:0] cnt_q, cnt_d;
  assign tick_o = en_i && (cnt_q == TW'(BIT_CYCLES - 1));
  always_comb cnt_d = (clr_i || !en_i || tick_o) ? '0 : cnt_q + TW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: framed parallel-in serial-out transmitter (START, data, [parity], STOP).
// Define PISO_PARITY_EN to insert an even-parity bit between the data bits and STOP.
module piso_serial_tx import piso_pkg::*; #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             dout_o,
  output logic             dout_bar_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q;
  logic [WIDTH-1:0] sr_q, sr_shift;
  logic [CW-1:0] bit_q;
  logic tick, accept, head;
`ifdef PISO_PARITY_EN
  logic par_q;
`endif
  assign accept   = load_valid_i && load_ready_o;
  assign head     = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];
  assign sr_shift = (MSB_FIRST != 0) ? sr_q << 1 : sr_q >> 1;
  piso_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr_i(accept), .en_i(busy_o), .tick_o(tick)
  );
  // dout_bar_o is written alongside dout_o everywhere so the pair stays complementary.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bit_q        <= '0;
      dout_o       <= LINE_IDLE;
      dout_bar_o   <= ~LINE_IDLE;
      load_ready_o <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          sr_q         <= load_data_i;
          bit_q        <= '0;
          state_q      <= START;
          dout_o       <= START_BIT;
          dout_bar_o   <= ~START_BIT;
          load_ready_o <= 1'b0;
          busy_o       <= 1'b1;
`ifdef PISO_PARITY_EN
          par_q        <= ^load_data_i;
`endif
        end
        START: if (tick) begin
          state_q    <= DATA;
          dout_o     <= head;
          dout_bar_o <= ~head;
          sr_q       <= sr_shift;
        end
        DATA: if (tick) begin
          if (bit_q == LAST) begin
`ifdef PISO_PARITY_EN
            state_q    <= PARITY;
            dout_o     <= par_q;
            dout_bar_o <= ~par_q;
`else
            state_q    <= STOP;
            dout_o     <= STOP_BIT;
            dout_bar_o <= ~STOP_BIT;
`endif
          end else begin
            bit_q      <= bit_q + CW'(1);
            dout_o     <= head;
            dout_bar_o <= ~head;
            sr_q       <= sr_shift;
          end
        end
        PARITY: if (tick) begin
          state_q    <= STOP;
          dout_o     <= STOP_BIT;
          dout_bar_o <= ~STOP_BIT;
        end
        STOP: if (tick) begin
          state_q      <= IDLE;
          load_ready_o <= 1'b1;
          busy_o       <= 1'b0;
          done_o       <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: two transmitter instances (fast MSB-first, slow LSB-first) checked every cycle
// against a frame-position model, plus literal frame patterns; honours PISO_PARITY_EN.
module tb_piso_serial_tx;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L   = W + 2 + P;
  localparam int BC0 = 1;
  localparam int BC1 = 4;

  logic clk = 1'b0, rst_n = 1'b1, load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic ready[2], dout[2], dout_bar[2], busy[2], done[2];
  int total = 0, bad = 0;
  bit chk_en = 1'b0;
  int pos[2] = '{-1, -1};
  logic [W-1:0] word[2] = '{8'h00, 8'h00};
  logic m_done[2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(W), .BIT_CYCLES(BC0), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst_n(rst_n), .load_valid_i(load_valid), .load_ready_o(ready[0]),
    .load_data_i(load_data), .dout_o(dout[0]), .dout_bar_o(dout_bar[0]),
    .busy_o(busy[0]), .done_o(done[0])
  );
  piso_serial_tx #(.WIDTH(W), .BIT_CYCLES(BC1), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst_n(rst_n), .load_valid_i(load_valid), .load_ready_o(ready[1]),
    .load_data_i(load_data), .dout_o(dout[1]), .dout_bar_o(dout_bar[1]),
    .busy_o(busy[1]), .done_o(done[1])
  );

  function automatic int bc(int k);
    return (k == 0) ? BC0 : BC1;
  endfunction

  // Expected line level from position within the frame: bit j = pos / BIT_CYCLES.
  function automatic logic exp_line(int k);
    int j;
    if (pos[k] < 0) return 1'b1;
    j = pos[k] / bc(k);
    if (j == 0) return 1'b0;
    if (j <= W) return (k == 0) ? word[k][W-j] : word[k][j-1];
    if (P == 1 && j == W + 1) return ^word[k];
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < 2; k++)
      if (!rst_n) begin
        pos[k]    <= -1;
        m_done[k] <= 1'b0;
      end else begin
        m_done[k] <= 1'b0;
        if (pos[k] < 0) begin
          if (load_valid) begin
            pos[k]  <= 0;
            word[k] <= load_data;
          end
        end else if (pos[k] == L * bc(k) - 1) begin
          pos[k]    <= -1;
          m_done[k] <= 1'b1;
        end else pos[k] <= pos[k] + 1;
      end

  always @(negedge clk)
    if (chk_en && rst_n)
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dout%0d", k), 32'(dout[k]), 32'(exp_line(k)));
        chk($sformatf("dout_bar%0d", k), 32'(dout_bar[k]), 32'(!exp_line(k)));
        chk($sformatf("ready%0d", k), 32'(ready[k]), 32'(pos[k] < 0));
        chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(pos[k] >= 0));
        chk($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
      end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 300 && !(ready[0] && ready[1]); i++) @(negedge clk);
    chk("idle_wait", 32'(ready[0] && ready[1]), 32'd1);
  endtask

  task automatic send(input logic [W-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_dout%0d", tag, k), 32'(dout[k]), 32'd1);
      chk($sformatf("%s_bar%0d", tag, k), 32'(dout_bar[k]), 32'd0);
      chk($sformatf("%s_ready%0d", tag, k), 32'(ready[k]), 32'd1);
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 32'd0);
      chk($sformatf("%s_done%0d", tag, k), 32'(done[k]), 32'd0);
    end
  endtask

  initial begin
    logic [10:0] seq, a5_exp, lsb_exp;
    logic all_busy;
`ifdef PISO_PARITY_EN
    a5_exp  = 11'b01010010101;
    lsb_exp = 11'b01000000011;
`else
    a5_exp  = 11'b00101001011;
    lsb_exp = 11'b00100000001;
`endif
    #1 rst_n = 1'b0;
    #1 chk_reset_state("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    // MSB-first 0xA5 on the fast instance, then done one frame later
    wait_idle();
    send(8'hA5);
    seq = '0;
    for (int i = 0; i < L; i++) begin
      if (i > 0) @(negedge clk);
      seq = {seq[9:0], dout[0]};
    end
    chk("a5_seq", 32'(seq), 32'(a5_exp));
    @(negedge clk);
    chk("a5_done", 32'(done[0]), 32'd1);
    // LSB-first 0x01 on the slow instance: each bit held BC1 cycles
    wait_idle();
    send(8'h01);
    all_busy = 1'b1;
    for (int i = 0; i < L * BC1; i++) begin
      if (i > 0) @(negedge clk);
      chk("lsb_bit", 32'(dout[1]), 32'(lsb_exp[L-1-i/BC1]));
      all_busy &= busy[1];
    end
    chk("lsb_busy", 32'(all_busy), 32'd1);
    @(negedge clk);
    chk("lsb_done", 32'(done[1]), 32'd1);
    // back-to-back with load_valid held: one idle-high cycle between frames
    wait_idle();
    load_valid = 1'b1;
    load_data  = 8'h00;
    @(negedge clk);
    load_data = 8'hFF;
    repeat (L) @(negedge clk);
    chk("b2b_gap_ready", 32'(ready[0]), 32'd1);
    chk("b2b_gap_line", 32'(dout[0]), 32'd1);
    chk("b2b_gap_done", 32'(done[0]), 32'd1);
    @(negedge clk);
    chk("b2b_start", 32'(dout[0]), 32'd0);
    chk("b2b_busy", 32'(busy[0]), 32'd1);
    load_valid = 1'b0;
`ifdef PISO_PARITY_EN
    wait_idle();
    send(8'h07);
    repeat (W + 1) @(negedge clk);
    chk("parity_07", 32'(dout[0]), 32'd1);
    wait_idle();
    send(8'h03);
    repeat (W + 1) @(negedge clk);
    chk("parity_03", 32'(dout[0]), 32'd0);
`endif
    // asynchronous reset in the middle of a frame
    wait_idle();
    send(8'h3C);
    repeat (3) @(negedge clk);
    chk("midframe_busy", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    // randomized traffic against the model
    repeat (600) begin
      @(negedge clk);
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = 8'($urandom);
    end
    load_valid = 1'b0;
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
